// File: rtl/tdm_mux_16to1.sv
// Time-division multiplexer: snapshots 16 lanes and an enable mask, then
// serializes each enabled lane (lowest index first) as a (data, sel) pair.
module tdm_mux_16to1 #(
  parameter int NUM_CH     = 16,
  parameter int SEL_W      = 4,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] din,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              ready,
  output logic              data,
  output logic [SEL_W-1:0]  sel,
  output logic              valid,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]        state;
  logic [NUM_CH-1:0] snap;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] pend_clr;
  logic              xfer;
  logic              last;

  // Lowest pending lane wins; pend is empty outside SCAN so sel rests at 0.
  always_comb begin
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) sel = SEL_W'(i);
    end
  end

  assign valid    = (state == SCAN);
  assign busy     = valid;
  assign data     = valid & snap[sel];
  assign pend_clr = pend & ~(NUM_CH'(1) << sel);
  assign xfer     = valid & ready;
  assign last     = xfer && (pend_clr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      snap       <= '0;
      pend       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (ch_en != '0) begin
              snap  <= din;
              pend  <= ch_en;
              state <= SCAN;
            end else begin
              frame_done <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (xfer) begin
            if (last) begin
              frame_done <= 1'b1;
              // Back-to-back frames recapture on the final transfer edge.
              if (CONTINUOUS && (ch_en != '0)) begin
                snap <= din;
                pend <= ch_en;
              end else begin
                pend  <= '0;
                state <= IDLE;
              end
            end else begin
              pend <= pend_clr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_mux_16to1.sv
// Self-checking bench for tdm_mux_16to1: table-driven frames on a one-shot
// instance plus hand sequences for async reset and continuous mode.
module tb_tdm_mux_16to1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] din;
  logic [15:0] ch_en;
  logic        ready;
  logic        data,  datac;
  logic [3:0]  sel,   selc;
  logic        valid, validc;
  logic        busy,  busyc;
  logic        fd,    fdc;

  int checks;
  int failures;

  typedef struct {
    logic        st;
    logic [15:0] d;
    logic [15:0] m;
    logic        rdy;
    logic        ev;
    logic [3:0]  esel;
    logic        ed;
    logic        ebusy;
    logic        efd;
  } vec_t;

  vec_t vecs[$];

  tdm_mux_16to1 #(.NUM_CH(16), .SEL_W(4), .CONTINUOUS(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .ch_en(ch_en),
    .ready(ready), .data(data), .sel(sel), .valid(valid), .busy(busy),
    .frame_done(fd)
  );

  tdm_mux_16to1 #(.NUM_CH(16), .SEL_W(4), .CONTINUOUS(1'b1)) dutc (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .ch_en(ch_en),
    .ready(ready), .data(datac), .sel(selc), .valid(validc), .busy(busyc),
    .frame_done(fdc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares the packed {valid, sel, data, busy, frame_done} view.
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got valid=%b sel=%0d data=%b busy=%b frame_done=%b, expected valid=%b sel=%0d data=%b busy=%b frame_done=%b",
               name, act[7], act[6:3], act[2], act[1], act[0],
               exp[7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic addVec(input logic st, input logic [15:0] d, input logic [15:0] m,
                        input logic rdy, input logic ev, input logic [3:0] esel,
                        input logic ed, input logic ebusy, input logic efd);
    vec_t v;
    v.st = st; v.d = d; v.m = m; v.rdy = rdy;
    v.ev = ev; v.esel = esel; v.ed = ed; v.ebusy = ebusy; v.efd = efd;
    vecs.push_back(v);
  endtask

  // Each entry checks the current outputs, then drives the next inputs.
  task automatic applyStimulus();
    foreach (vecs[i]) begin
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), {valid, sel, data, busy, fd},
                  {vecs[i].ev, vecs[i].esel, vecs[i].ed, vecs[i].ebusy, vecs[i].efd});
      start = vecs[i].st;
      din   = vecs[i].d;
      ch_en = vecs[i].m;
      ready = vecs[i].rdy;
    end
  endtask

  initial begin
    logic [15:0] pat;
    logic [15:0] pat2;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;
    ch_en = '0;
    ready = 1'b0;

    // Full frame, every lane enabled
    pat = 16'hA5C3;
    addVec(1, pat, 16'hFFFF, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) addVec(0, pat, 16'hFFFF, 1, 1, 4'(k), pat[k], 1, 0);
    addVec(0, pat, 16'hFFFF, 1, 0, 0, 0, 0, 1);
    addVec(0, pat, 16'hFFFF, 1, 0, 0, 0, 0, 0);
    // Sparse mask
    addVec(1, 16'h8001, 16'h8101, 1, 0, 0, 0, 0, 0);
    addVec(0, 16'h8001, 16'h8101, 1, 1, 0, 1, 1, 0);
    addVec(0, 16'h8001, 16'h8101, 1, 1, 8, 0, 1, 0);
    addVec(0, 16'h8001, 16'h8101, 1, 1, 15, 1, 1, 0);
    addVec(0, 16'h8001, 16'h8101, 1, 0, 0, 0, 0, 1);
    // Backpressure on lane 3 for five cycles
    pat2 = 16'h0008;
    addVec(1, pat2, 16'hFFFF, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) addVec(0, pat2, 16'hFFFF, 1, 1, 4'(k), 0, 1, 0);
    for (int k = 0; k < 5; k++) addVec(0, pat2, 16'hFFFF, 0, 1, 3, 1, 1, 0);
    addVec(0, pat2, 16'hFFFF, 1, 1, 3, 1, 1, 0);
    for (int k = 4; k < 16; k++) addVec(0, pat2, 16'hFFFF, 1, 1, 4'(k), 0, 1, 0);
    addVec(0, pat2, 16'hFFFF, 1, 0, 0, 0, 0, 1);
    // Empty mask
    addVec(1, 16'h1234, 16'h0000, 1, 0, 0, 0, 0, 0);
    addVec(0, 16'h1234, 16'h0000, 1, 0, 0, 0, 0, 1);
    addVec(0, 16'h1234, 16'h0000, 1, 0, 0, 0, 0, 0);
    // Start and din changes while busy are ignored
    addVec(1, 16'h00A0, 16'h00F0, 1, 0, 0, 0, 0, 0);
    addVec(1, 16'hFF0F, 16'hFFFF, 1, 1, 4, 0, 1, 0);
    addVec(0, 16'h0000, 16'hFFFF, 1, 1, 5, 1, 1, 0);
    addVec(0, 16'h0000, 16'hFFFF, 1, 1, 6, 0, 1, 0);
    addVec(0, 16'h0000, 16'hFFFF, 1, 1, 7, 1, 1, 0);
    addVec(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 1);
    addVec(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    checkOutput("reset_state", {valid, sel, data, busy, fd}, 8'h00);
    rst_n = 1'b1;

    applyStimulus();

    // Async reset in the middle of a frame
    @(negedge clk);
    start = 1'b1; din = 16'hFFFF; ch_en = 16'hFFFF; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset", {valid, sel, data, busy, fd}, {1'b1, 4'd1, 1'b1, 1'b1, 1'b0});
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", {valid, sel, data, busy, fd}, 8'h00);
    @(negedge clk);
    checkOutput("reset_held", {valid, sel, data, busy, fd}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("no_done_after_reset", {valid, sel, data, busy, fd}, 8'h00);
    start = 1'b1; din = 16'h0001; ch_en = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    checkOutput("clean_frame", {valid, sel, data, busy, fd}, {1'b1, 4'd0, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    checkOutput("clean_frame_done", {valid, sel, data, busy, fd}, {1'b0, 4'd0, 1'b0, 1'b0, 1'b1});

    // Continuous mode, two-lane mask
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; din = 16'h0002; ch_en = 16'h0003; ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      checkOutput($sformatf("cont%0d", k), {validc, selc, datac, busyc, fdc},
                  {1'b1, 4'(k % 2), 1'(k % 2), 1'b1, 1'((k >= 2) && (k % 2 == 0))});
    end
    ch_en = 16'h0000;
    @(negedge clk);
    checkOutput("cont_stop", {validc, selc, datac, busyc, fdc}, {1'b0, 4'd0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    checkOutput("cont_idle", {validc, selc, datac, busyc, fdc}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
